// File: rtl/spi_minion_stream_adapter.sv
// SPI mode-0 minion bridging {wr_val, rd_req, data} frames to valid/ready streams in both directions.
// Frame effects land SYNC_STAGES+1 clk after cs rises; RX drops (rx_overflow) when full, send_rdy deasserts when TX is full.

module spi_minion_stream_adapter_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    // Callers gate push/pop against full/empty; this block never refuses.
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
endmodule

module spi_minion_stream_adapter #(
    parameter int DATA_W      = 32,
    parameter int RX_DEPTH    = 4,
    parameter int TX_DEPTH    = 4,
    parameter int PARITY_MODE = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic [DATA_W-1:0] recv_msg,
    output logic              recv_val,
    input  logic              recv_rdy,
    input  logic [DATA_W-1:0] send_msg,
    input  logic              send_val,
    output logic              send_rdy,
    output logic              minion_parity,
    output logic              adapter_parity,
    output logic              rx_overflow,
    output logic              frame_error
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME = FRAME_W[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_FRAME + 1'b1;

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
        case (PARITY_MODE)
            1:       parity_of = ^d;
            2:       parity_of = ~^d;
            default: parity_of = 1'b0;
        endcase
    endfunction

    // cs chain resets low so a cs already low at reset release never looks like a falling edge.
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
    logic cs_last_q, cs_last_d, sclk_last_q, sclk_last_d;
    logic cs_s, sclk_s, mosi_s, cs_fall, cs_rise, sclk_rise, sclk_fall;

    logic               armed_q, armed_d, tx_avail_q, tx_avail_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] shift_in_q, shift_in_d, shift_out_q, shift_out_d;
    logic               rx_overflow_q, rx_overflow_d, frame_error_q, frame_error_d;
    logic               minion_parity_q, minion_parity_d;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic              frame_wr, frame_rd;
    logic [DATA_W-1:0] frame_dat;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_last_q & ~cs_s;
    assign cs_rise   = ~cs_last_q & cs_s;
    assign sclk_rise = ~sclk_last_q & sclk_s;
    assign sclk_fall = sclk_last_q & ~sclk_s;

    assign frame_wr  = shift_in_q[FRAME_W-1];
    assign frame_rd  = shift_in_q[FRAME_W-2];
    assign frame_dat = shift_in_q[DATA_W-1:0];

    assign rx_pop  = ~rx_empty & recv_rdy;
    assign tx_push = send_val & ~tx_full;

    always_comb begin
        cs_sync_d       = {cs_sync_q[SYNC_STAGES-2:0], cs};
        sclk_sync_d     = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_last_d       = cs_s;
        sclk_last_d     = sclk_s;
        armed_d         = armed_q;
        tx_avail_d      = tx_avail_q;
        bit_cnt_d       = bit_cnt_q;
        shift_in_d      = shift_in_q;
        shift_out_d     = shift_out_q;
        rx_overflow_d   = rx_overflow_q;
        frame_error_d   = frame_error_q;
        rx_push         = 1'b0;
        tx_pop          = 1'b0;

        if (cs_fall) begin
            armed_d     = 1'b1;
            bit_cnt_d   = '0;
            shift_in_d  = '0;
            tx_avail_d  = ~tx_empty;
            shift_out_d = {~tx_empty, ~rx_full, (tx_empty ? {DATA_W{1'b0}} : tx_head)};
        end else if (cs_rise) begin
            armed_d     = 1'b0;
            shift_out_d = '0;
            if (armed_q) begin
                if (bit_cnt_q == CNT_FRAME) begin
                    if (frame_wr) begin
                        // A same-cycle consumer pop frees the slot even when full.
                        if (~rx_full | rx_pop) begin
                            rx_push = 1'b1;
                        end else begin
                            rx_overflow_d = 1'b1;
                        end
                    end
                    tx_pop = frame_rd & tx_avail_q;
                end else begin
                    frame_error_d = 1'b1;
                end
            end
        end else if (armed_q) begin
            if (sclk_rise) begin
                shift_in_d = {shift_in_q[FRAME_W-2:0], mosi_s};
                if (bit_cnt_q != CNT_MAX) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (sclk_fall) begin
                shift_out_d = {shift_out_q[FRAME_W-2:0], 1'b0};
            end
        end

        minion_parity_d = rx_push ? parity_of(frame_dat) : minion_parity_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync_q       <= '0;
            sclk_sync_q     <= '0;
            mosi_sync_q     <= '0;
            cs_last_q       <= 1'b0;
            sclk_last_q     <= 1'b0;
            armed_q         <= 1'b0;
            tx_avail_q      <= 1'b0;
            bit_cnt_q       <= '0;
            shift_in_q      <= '0;
            shift_out_q     <= '0;
            rx_overflow_q   <= 1'b0;
            frame_error_q   <= 1'b0;
            minion_parity_q <= 1'b0;
        end else begin
            cs_sync_q       <= cs_sync_d;
            sclk_sync_q     <= sclk_sync_d;
            mosi_sync_q     <= mosi_sync_d;
            cs_last_q       <= cs_last_d;
            sclk_last_q     <= sclk_last_d;
            armed_q         <= armed_d;
            tx_avail_q      <= tx_avail_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_in_q      <= shift_in_d;
            shift_out_q     <= shift_out_d;
            rx_overflow_q   <= rx_overflow_d;
            frame_error_q   <= frame_error_d;
            minion_parity_q <= minion_parity_d;
        end
    end

    spi_minion_stream_adapter_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rx_push),
        .push_dat (frame_dat),
        .pop      (rx_pop),
        .head_dat (recv_msg),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    spi_minion_stream_adapter_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_push),
        .push_dat (send_msg),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    assign miso           = shift_out_q[FRAME_W-1];
    assign recv_val       = ~rx_empty;
    assign send_rdy       = ~tx_full;
    assign minion_parity  = minion_parity_q;
    assign adapter_parity = recv_val & parity_of(recv_msg);
    assign rx_overflow    = rx_overflow_q;
    assign frame_error    = frame_error_q;
endmodule

// File: tb/tb_spi_minion_stream_adapter.sv
// Drives SPI frames bit-by-bit and compares miso, both streams and flags against queue-based expectations.
module tb_spi_minion_stream_adapter;
    localparam int DATA_W   = 32;
    localparam int FRAME_W  = DATA_W + 2;
    localparam int RX_DEPTH = 4;
    localparam int TX_DEPTH = 4;
    localparam int HALF     = 8;
    localparam int SYNC     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cs = 1'b1;
    logic              sclk = 1'b0;
    logic              mosi = 1'b0;
    logic              miso;
    logic [DATA_W-1:0] recv_msg;
    logic              recv_val;
    logic              recv_rdy = 1'b0;
    logic [DATA_W-1:0] send_msg = '0;
    logic              send_val = 1'b0;
    logic              send_rdy;
    logic              minion_parity;
    logic              adapter_parity;
    logic              rx_overflow;
    logic              frame_error;

    int vecs = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] tx_q[$];
    logic exp_ovf  = 1'b0;
    logic exp_ferr = 1'b0;
    logic exp_mpar = 1'b0;

    spi_minion_stream_adapter #(
        .DATA_W(DATA_W), .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH),
        .PARITY_MODE(1), .SYNC_STAGES(SYNC)
    ) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
        .minion_parity(minion_parity), .adapter_parity(adapter_parity),
        .rx_overflow(rx_overflow), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".recv_val"}, recv_val, rx_q.size() != 0);
        if (rx_q.size() != 0) begin
            check({tag, ".recv_msg"}, recv_msg, rx_q[0]);
            check({tag, ".adapter_parity"}, adapter_parity, ^rx_q[0]);
        end else begin
            check({tag, ".adapter_parity"}, adapter_parity, 1'b0);
        end
        check({tag, ".minion_parity"}, minion_parity, exp_mpar);
        check({tag, ".rx_overflow"}, rx_overflow, exp_ovf);
        check({tag, ".frame_error"}, frame_error, exp_ferr);
        check({tag, ".send_rdy"}, send_rdy, tx_q.size() < TX_DEPTH);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (HALF) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    // pulse raises recv_rdy for exactly the cycle in which the frame's push lands.
    task automatic spi_frame(input logic [FRAME_W-1:0] f, input int nbits, input bit pulse,
                             output logic [FRAME_W-1:0] got);
        logic m;
        got = '0;
        @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(f[FRAME_W-1-i], m);
            got[FRAME_W-1-i] = m;
        end
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC) @(negedge clk);
        if (pulse) recv_rdy = 1'b1;
        @(negedge clk);
        recv_rdy = 1'b0;
        repeat (HALF) @(negedge clk);
        mosi = 1'b0;
    endtask

    task automatic do_frame(input logic wr, input logic rd, input logic [DATA_W-1:0] dat,
                            input bit pulse, input string tag);
        logic [FRAME_W-1:0] exp_miso;
        logic [FRAME_W-1:0] got;
        logic tx_avail;
        tx_avail = (tx_q.size() != 0);
        exp_miso = {tx_avail, rx_q.size() < RX_DEPTH, (tx_avail ? tx_q[0] : {DATA_W{1'b0}})};
        spi_frame({wr, rd, dat}, FRAME_W, pulse, got);
        check({tag, ".miso"}, got, exp_miso);
        if (pulse && rx_q.size() != 0) void'(rx_q.pop_front());
        if (wr) begin
            if (rx_q.size() < RX_DEPTH) begin
                rx_q.push_back(dat);
                exp_mpar = ^dat;
            end else begin
                exp_ovf = 1'b1;
            end
        end
        if (rd && tx_avail) void'(tx_q.pop_front());
        check_state(tag);
    endtask

    task automatic do_short(input logic [DATA_W-1:0] dat);
        logic [FRAME_W-1:0] got;
        logic tx_avail;
        tx_avail = (tx_q.size() != 0);
        spi_frame({2'b10, dat}, FRAME_W - 3, 0, got);
        check("short.miso_msb", got[FRAME_W-1], tx_avail);
        exp_ferr = 1'b1;
        check_state("short");
    endtask

    task automatic drain(input string tag);
        while (rx_q.size() != 0) begin
            check({tag, ".val"}, recv_val, 1'b1);
            check({tag, ".msg"}, recv_msg, rx_q[0]);
            check({tag, ".apar"}, adapter_parity, ^rx_q[0]);
            recv_rdy = 1'b1;
            @(negedge clk);
            recv_rdy = 1'b0;
            void'(rx_q.pop_front());
        end
        check({tag, ".empty_val"}, recv_val, 1'b0);
        check({tag, ".empty_apar"}, adapter_parity, 1'b0);
    endtask

    task automatic push_tx(input logic [DATA_W-1:0] d);
        check("push.send_rdy", send_rdy, tx_q.size() < TX_DEPTH);
        send_msg = d;
        send_val = 1'b1;
        @(negedge clk);
        send_val = 1'b0;
        if (tx_q.size() < TX_DEPTH) tx_q.push_back(d);
    endtask

    initial begin
        logic m;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        check("rst.miso", miso, 1'b0);
        check("rst.recv_val", recv_val, 1'b0);
        check("rst.send_rdy", send_rdy, 1'b1);
        check("rst.minion_parity", minion_parity, 1'b0);
        check("rst.adapter_parity", adapter_parity, 1'b0);
        check("rst.rx_overflow", rx_overflow, 1'b0);
        check("rst.frame_error", frame_error, 1'b0);

        do_frame(1'b1, 1'b0, 32'hDEADBEEF, 0, "deadbeef");
        check("deadbeef.msg_const", recv_msg, 32'hDEADBEEF);
        drain("d1");

        push_tx(32'h0000_0007);
        do_frame(1'b0, 1'b1, 32'h0, 0, "txread");
        do_frame(1'b0, 1'b0, 32'h1234, 0, "txempty");

        for (int i = 0; i < RX_DEPTH; i++) do_frame(1'b1, 1'b0, $urandom, 0, "fill");
        do_frame(1'b1, 1'b0, $urandom, 1, "fullpop");
        drain("d2");

        for (int i = 0; i <= RX_DEPTH; i++) do_frame(1'b1, 1'b0, $urandom, 0, "ovf");
        check("ovf.flag", rx_overflow, 1'b1);
        drain("d3");

        do_short($urandom);
        do_frame(1'b1, 1'b0, $urandom, 0, "after_short");
        drain("d4");

        for (int i = 0; i < TX_DEPTH; i++) push_tx($urandom);
        do_frame(1'b1, 1'b0, $urandom, 0, "pre_rst");
        @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)), m);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        rx_q.delete();
        tx_q.delete();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        exp_mpar = 1'b0;
        check("midrst.miso", miso, 1'b0);
        check_state("midrst");
        reset = 1'b0;
        for (int i = 5; i < FRAME_W; i++) spi_bit(1'b1, m);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check("midrst_after.miso", miso, 1'b0);
        check_state("midrst_after");

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) push_tx($urandom);
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 3) == 0), "rand");
            if ($urandom_range(0, 3) == 0) drain("rdrain");
        end
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
